bus_xfer_sequencer: RTL and testbench

BUS_XFER_SEQUENCER -- requirements
Module: bus_xfer_sequencer

---
 rtl/bus_seq_pkg.sv | 22 ++
 rtl/idx_decode.sv | 18 +
 rtl/bus_xfer_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_bus_xfer_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_seq_pkg.sv
// Shared encodings for the bus transfer sequencer: command opcodes and FSM states.
package bus_seq_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_LDI  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_S3   = 2'd3
  } state_e;

  // Plain-vector aliases of the state encodings for the state register.
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_S1   = ST_S1;
  localparam logic [1:0] S_S2   = ST_S2;
  localparam logic [1:0] S_S3   = ST_S3;

endpackage

// File: rtl/idx_decode.sv
// Binary index to N-bit one-hot decoder with a global enable.
module idx_decode #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [IW-1:0] idx_i,
  input  logic          en_i,
  output logic [N-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = en_i && (idx_i == IW'(i));
    end
  end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Sequences register-to-register bus transfers (NOP/MOV/LDI, plus SWAP through a
// scratch register when BUS_SEQ_SWAP_EN is defined). All outputs are registered.
module bus_xfer_sequencer
  import bus_seq_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int WIDTH = 32,
  parameter int TMP   = NREG - 1
) (
  input  logic                    clk,
  input  logic                    reset,
  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_src,
  input  logic [$clog2(NREG)-1:0] cmd_dst,
  input  logic [WIDTH-1:0]        cmd_const,
  output logic [NREG-1:0]         reg_in,
  output logic [NREG-1:0]         reg_out,
  output logic                    const_en,
  output logic [WIDTH-1:0]        const_val,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              dbg_state
);

  localparam int IW = $clog2(NREG);
  localparam logic [IW-1:0] TMP_IDX = IW'(TMP);

  logic [1:0]       state_q, state_d;
  logic [NREG-1:0]  reg_in_q, reg_in_d, reg_out_q, reg_out_d;
  logic             const_en_q, const_en_d;
  logic [WIDTH-1:0] const_val_q, const_val_d;
  logic             done_q, done_d, err_q, err_d;
  logic [IW-1:0]    in_idx_d, out_idx_d;
  logic             in_en_d, out_en_d;
  logic             src_oob, dst_oob, swap_bad, cmd_illegal;

`ifdef BUS_SEQ_SWAP_EN
  logic [IW-1:0] src_q, src_d, dst_q, dst_d;
  logic          swap_q, swap_d;
`endif

  assign src_oob  = int'(cmd_src) >= NREG;
  assign dst_oob  = int'(cmd_dst) >= NREG;
  assign swap_bad = (cmd_op == OP_SWAP) &&
                    ((cmd_src == TMP_IDX) || (cmd_dst == TMP_IDX) || (cmd_src == cmd_dst));

  // NOP touches no index, LDI only the destination, MOV/SWAP both.
  always_comb begin
    cmd_illegal = ((cmd_op == OP_MOV) || (cmd_op == OP_SWAP)) && src_oob;
    cmd_illegal = cmd_illegal || ((cmd_op != OP_NOP) && dst_oob) || swap_bad;
`ifndef BUS_SEQ_SWAP_EN
    cmd_illegal = cmd_illegal || (cmd_op == OP_SWAP);
`endif
  end

  always_comb begin
    state_d     = state_q;
    in_idx_d    = '0;
    in_en_d     = 1'b0;
    out_idx_d   = '0;
    out_en_d    = 1'b0;
    const_en_d  = 1'b0;
    const_val_d = const_val_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef BUS_SEQ_SWAP_EN
    src_d       = src_q;
    dst_d       = dst_q;
    swap_d      = swap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_illegal) begin
            err_d = 1'b1;
          end else begin
            state_d = S_S1;
            case (cmd_op)
              OP_NOP: done_d = 1'b1;
              OP_MOV: begin
                done_d = 1'b1;
                // A self-move is a no-op step: nothing is driven or loaded.
                if (cmd_src != cmd_dst) begin
                  out_idx_d = cmd_src;
                  out_en_d  = 1'b1;
                  in_idx_d  = cmd_dst;
                  in_en_d   = 1'b1;
                end
              end
              OP_LDI: begin
                done_d      = 1'b1;
                const_en_d  = 1'b1;
                const_val_d = cmd_const;
                in_idx_d    = cmd_dst;
                in_en_d     = 1'b1;
              end
              default: begin
`ifdef BUS_SEQ_SWAP_EN
                out_idx_d = cmd_src;
                out_en_d  = 1'b1;
                in_idx_d  = TMP_IDX;
                in_en_d   = 1'b1;
                src_d     = cmd_src;
                dst_d     = cmd_dst;
                swap_d    = 1'b1;
`endif
              end
            endcase
          end
        end
      end
      S_S1: begin
        state_d = S_IDLE;
`ifdef BUS_SEQ_SWAP_EN
        if (swap_q) begin
          state_d   = S_S2;
          out_idx_d = dst_q;
          out_en_d  = 1'b1;
          in_idx_d  = src_q;
          in_en_d   = 1'b1;
        end
`endif
      end
`ifdef BUS_SEQ_SWAP_EN
      S_S2: begin
        state_d   = S_S3;
        out_idx_d = TMP_IDX;
        out_en_d  = 1'b1;
        in_idx_d  = dst_q;
        in_en_d   = 1'b1;
        done_d    = 1'b1;
      end
      S_S3: begin
        state_d = S_IDLE;
        swap_d  = 1'b0;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  idx_decode #(.N(NREG), .IW(IW)) u_in_dec (
    .idx_i    (in_idx_d),
    .en_i     (in_en_d),
    .onehot_o (reg_in_d)
  );

  idx_decode #(.N(NREG), .IW(IW)) u_out_dec (
    .idx_i    (out_idx_d),
    .en_i     (out_en_d),
    .onehot_o (reg_out_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      reg_in_q    <= '0;
      reg_out_q   <= '0;
      const_en_q  <= 1'b0;
      const_val_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef BUS_SEQ_SWAP_EN
      src_q       <= '0;
      dst_q       <= '0;
      swap_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      reg_in_q    <= reg_in_d;
      reg_out_q   <= reg_out_d;
      const_en_q  <= const_en_d;
      const_val_q <= const_val_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef BUS_SEQ_SWAP_EN
      src_q       <= src_d;
      dst_q       <= dst_d;
      swap_q      <= swap_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign reg_in    = reg_in_q;
  assign reg_out   = reg_out_q;
  assign const_en  = const_en_q;
  assign const_val = const_val_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed bench for bus_xfer_sequencer with register models on a shared bus.
// Expectations follow BUS_SEQ_SWAP_EN when the bench is built with it.
module tb_bus_xfer_sequencer;

  localparam logic [1:0] NOP = 2'b00, MOV = 2'b01, LDI = 2'b10, SWP = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [2:0]  cmd_src = '0, cmd_dst = '0;
  logic [31:0] cmd_const = '0;
  logic        cmd_ready, const_en, done, err;
  logic [7:0]  reg_in, reg_out;
  logic [31:0] const_val;
  logic [1:0]  dbg_state;

  // Second instance with NREG=6 so out-of-range indices are representable.
  logic        c2_valid = 1'b0;
  logic [1:0]  c2_op = '0;
  logic [2:0]  c2_src = '0, c2_dst = '0;
  logic [31:0] c2_const = '0;
  logic        c2_ready, c2_const_en, c2_done, c2_err;
  logic [5:0]  r2_in, r2_out;
  logic [31:0] c2_const_val;
  logic [1:0]  c2_state;

  int checks = 0;
  int errors = 0;
  int excl_viol = 0;

  always #5 clk = ~clk;

  bus_xfer_sequencer #(.NREG(8), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_const(cmd_const),
    .reg_in(reg_in), .reg_out(reg_out), .const_en(const_en), .const_val(const_val),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  bus_xfer_sequencer #(.NREG(6), .WIDTH(32)) dut6 (
    .clk(clk), .reset(reset), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
    .cmd_op(c2_op), .cmd_src(c2_src), .cmd_dst(c2_dst), .cmd_const(c2_const),
    .reg_in(r2_in), .reg_out(r2_out), .const_en(c2_const_en), .const_val(c2_const_val),
    .done(c2_done), .err(c2_err), .dbg_state(c2_state)
  );

  // System registers sharing one bus.
  logic [31:0] m [8];
  logic [31:0] bus;
  always_comb begin
    bus = const_en ? const_val : 32'd0;
    for (int i = 0; i < 8; i++) if (reg_out[i]) bus = bus | m[i];
  end
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (reg_in[i]) m[i] <= bus;
  end

  always @(negedge clk) begin
    if (!$onehot0({reg_out, const_en}) || !$onehot0(reg_in)) excl_viol++;
    if (!$onehot0({r2_out, c2_const_en}) || !$onehot0(r2_in)) excl_viol++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                       input logic [31:0] c);
    @(negedge clk);
    cmd_op = op; cmd_src = s; cmd_dst = d; cmd_const = c; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic issue6(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d);
    @(negedge clk);
    c2_op = op; c2_src = s; c2_dst = d; c2_valid = 1'b1;
    @(posedge clk); #1;
    c2_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({reg_in, reg_out} !== 16'h0) begin errors++; $display("FAIL rst_enables got=%h exp=0000", {reg_in, reg_out}); end
    checks++; if ({const_en, done, err} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {const_en, done, err}); end
    checks++; if (const_val !== 32'd0) begin errors++; $display("FAIL rst_const_val got=%0d exp=0", const_val); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_ldi();
    issue(LDI, 3'd0, 3'd0, 32'd50);
    checks++; if (reg_in !== 8'h01) begin errors++; $display("FAIL ldi_reg_in got=%h exp=01", reg_in); end
    checks++; if ({const_en, done, reg_out} !== {2'b11, 8'h00}) begin errors++; $display("FAIL ldi_ctl got=%b exp=1100000000", {const_en, done, reg_out}); end
    checks++; if (const_val !== 32'd50) begin errors++; $display("FAIL ldi_const_val got=%0d exp=50", const_val); end
    checks++; if ({dbg_state, cmd_ready} !== 3'b010) begin errors++; $display("FAIL ldi_state got=%b exp=010", {dbg_state, cmd_ready}); end
    step();
    checks++; if (m[0] !== 32'd50) begin errors++; $display("FAIL ldi_reg0 got=%0d exp=50", m[0]); end
    checks++; if ({const_en, done, dbg_state} !== 4'b0000) begin errors++; $display("FAIL ldi_after got=%b exp=0000", {const_en, done, dbg_state}); end
    checks++; if (const_val !== 32'd50) begin errors++; $display("FAIL ldi_const_hold got=%0d exp=50", const_val); end
  endtask

  task automatic test_mov();
    issue(MOV, 3'd0, 3'd1, 32'd0);
    checks++; if ({reg_out, reg_in} !== 16'h0102) begin errors++; $display("FAIL mov_enables got=%h exp=0102", {reg_out, reg_in}); end
    checks++; if ({const_en, done} !== 2'b01) begin errors++; $display("FAIL mov_flags got=%b exp=01", {const_en, done}); end
    step();
    checks++; if ({m[0], m[1]} !== {32'd50, 32'd50}) begin errors++; $display("FAIL mov_regs got=%0d,%0d exp=50,50", m[0], m[1]); end
  endtask

  task automatic test_swap();
    issue(LDI, 3'd0, 3'd0, 32'd70);
    step();
    issue(SWP, 3'd0, 3'd1, 32'd0);
`ifdef BUS_SEQ_SWAP_EN
    checks++; if ({dbg_state, reg_out, reg_in, done} !== {2'd1, 8'h01, 8'h80, 1'b0}) begin errors++; $display("FAIL swap_s1 got=%h exp=%h", {dbg_state, reg_out, reg_in, done}, {2'd1, 8'h01, 8'h80, 1'b0}); end
    step();
    checks++; if ({dbg_state, reg_out, reg_in, done} !== {2'd2, 8'h02, 8'h01, 1'b0}) begin errors++; $display("FAIL swap_s2 got=%h exp=%h", {dbg_state, reg_out, reg_in, done}, {2'd2, 8'h02, 8'h01, 1'b0}); end
    step();
    checks++; if ({dbg_state, reg_out, reg_in, done} !== {2'd3, 8'h80, 8'h02, 1'b1}) begin errors++; $display("FAIL swap_s3 got=%h exp=%h", {dbg_state, reg_out, reg_in, done}, {2'd3, 8'h80, 8'h02, 1'b1}); end
    step();
    checks++; if ({dbg_state, done} !== 3'b000) begin errors++; $display("FAIL swap_end got=%b exp=000", {dbg_state, done}); end
    checks++; if ({m[0], m[1], m[7]} !== {32'd50, 32'd70, 32'd70}) begin errors++; $display("FAIL swap_regs got=%0d,%0d,%0d exp=50,70,70", m[0], m[1], m[7]); end
`else
    checks++; if ({err, done, dbg_state} !== 4'b1000) begin errors++; $display("FAIL swap_off_err got=%b exp=1000", {err, done, dbg_state}); end
    checks++; if ({reg_out, reg_in, const_en} !== 17'h0) begin errors++; $display("FAIL swap_off_en got=%h exp=0", {reg_out, reg_in, const_en}); end
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL swap_off_pulse got=%b exp=0", err); end
    checks++; if ({m[0], m[1]} !== {32'd70, 32'd50}) begin errors++; $display("FAIL swap_off_regs got=%0d,%0d exp=70,50", m[0], m[1]); end
`endif
  endtask

  task automatic test_illegal();
    issue(SWP, 3'd2, 3'd2, 32'd0);
    checks++; if ({err, dbg_state, reg_out, reg_in} !== {1'b1, 18'h0}) begin errors++; $display("FAIL swap_same got=%h exp=%h", {err, dbg_state, reg_out, reg_in}, {1'b1, 18'h0}); end
    step();
`ifdef BUS_SEQ_SWAP_EN
    issue(SWP, 3'd0, 3'd7, 32'd0);
    checks++; if ({err, dbg_state, reg_out, reg_in} !== {1'b1, 18'h0}) begin errors++; $display("FAIL swap_tmp got=%h exp=%h", {err, dbg_state, reg_out, reg_in}, {1'b1, 18'h0}); end
    step();
`endif
    issue(MOV, 3'd3, 3'd3, 32'd0);
    checks++; if ({done, err, dbg_state, reg_out, reg_in, const_en} !== {1'b1, 1'b0, 2'd1, 17'h0}) begin errors++; $display("FAIL mov_self got=%h", {done, err, dbg_state, reg_out, reg_in, const_en}); end
    step();
    issue(NOP, 3'd4, 3'd5, 32'd0);
    checks++; if ({done, err, dbg_state, reg_out, reg_in, const_en} !== {1'b1, 1'b0, 2'd1, 17'h0}) begin errors++; $display("FAIL nop got=%h", {done, err, dbg_state, reg_out, reg_in, const_en}); end
    step();
    issue6(MOV, 3'd7, 3'd0);
    checks++; if ({c2_err, c2_state, r2_out, r2_in, c2_done} !== {1'b1, 15'h0}) begin errors++; $display("FAIL oob_src got=%h", {c2_err, c2_state, r2_out, r2_in, c2_done}); end
    step();
    checks++; if (c2_err !== 1'b0) begin errors++; $display("FAIL oob_pulse got=%b exp=0", c2_err); end
    issue6(LDI, 3'd0, 3'd6);
    checks++; if ({c2_err, c2_state, r2_in, c2_const_en} !== {1'b1, 9'h0}) begin errors++; $display("FAIL oob_dst got=%h", {c2_err, c2_state, r2_in, c2_const_en}); end
    step();
    issue6(MOV, 3'd1, 3'd2);
    checks++; if ({c2_err, c2_done, r2_out, r2_in} !== {2'b01, 6'h02, 6'h04}) begin errors++; $display("FAIL nreg6_mov got=%h", {c2_err, c2_done, r2_out, r2_in}); end
    step();
  endtask

  task automatic test_reset_mid();
    int noisy = 0;
`ifdef BUS_SEQ_SWAP_EN
    issue(SWP, 3'd2, 3'd3, 32'd0);
    step();
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL mid_in_s2 got=%0d exp=2", dbg_state); end
    #2 reset = 1'b1;
    #1;
`else
    issue(LDI, 3'd0, 3'd4, 32'd99);
    checks++; if (const_en !== 1'b1) begin errors++; $display("FAIL mid_in_s1 got=%b exp=1", const_en); end
    #2 reset = 1'b1;
    #1;
    checks++; if (const_val !== 32'd0) begin errors++; $display("FAIL mid_const_val got=%0d exp=0", const_val); end
`endif
    checks++; if ({reg_out, reg_in, const_en, done, dbg_state} !== 20'h0) begin errors++; $display("FAIL mid_async got=%h exp=0", {reg_out, reg_in, const_en, done, dbg_state}); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if ({reg_out, reg_in, done} !== 17'h0) noisy++;
    end
    checks++; if (noisy != 0) begin errors++; $display("FAIL mid_abort got=%0d active cycles exp=0", noisy); end
    issue(MOV, 3'd0, 3'd5, 32'd0);
    checks++; if ({reg_out, reg_in, done} !== {8'h01, 8'h20, 1'b1}) begin errors++; $display("FAIL mid_next_mov got=%h", {reg_out, reg_in, done}); end
    step();
`ifdef BUS_SEQ_SWAP_EN
    checks++; if (m[5] !== 32'd50) begin errors++; $display("FAIL mid_reg5 got=%0d exp=50", m[5]); end
`else
    checks++; if (m[5] !== 32'd70) begin errors++; $display("FAIL mid_reg5 got=%0d exp=70", m[5]); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [4] = '{LDI, LDI, MOV, MOV};
    logic [2:0]  srcs [4] = '{3'd0, 3'd0, 3'd0, 3'd1};
    logic [2:0]  dsts [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] cs [4] = '{32'd11, 32'd22, 32'd0, 32'd0};
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      cmd_op = ops[k]; cmd_src = srcs[k]; cmd_dst = dsts[k]; cmd_const = cs[k]; cmd_valid = 1'b1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%b exp=1", k, cmd_ready); end
      @(posedge clk); #1;
      checks++; if ({done, dbg_state} !== 3'b101) begin errors++; $display("FAIL b2b_accept%0d got=%b exp=101", k, {done, dbg_state}); end
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy%0d got=%b exp=0", k, cmd_ready); end
      @(posedge clk); #1;
      checks++; if ({done, dbg_state} !== 3'b000) begin errors++; $display("FAIL b2b_idle%0d got=%b exp=000", k, {done, dbg_state}); end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++; if ({m[0], m[1], m[2], m[3]} !== {32'd11, 32'd22, 32'd11, 32'd22}) begin errors++; $display("FAIL b2b_regs got=%0d,%0d,%0d,%0d exp=11,22,11,22", m[0], m[1], m[2], m[3]); end
    checks++; if (excl_viol != 0) begin errors++; $display("FAIL bus_exclusive got=%0d violations exp=0", excl_viol); end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_mov();
    test_swap();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
